// File: rtl/iiitb_vm_pkg.sv
// Shared types and coin helpers for the multi-product vending controller.
// Coin codes double as change codes so the hopper driver uses one encoding.
package iiitb_vm_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_5    = 2'd1;
    localparam logic [1:0] COIN_10   = 2'd2;
    localparam logic [1:0] COIN_20   = 2'd3;

    // Widest credit the helpers accept; callers zero-extend into this.
    localparam int GREEDY_W = 16;

    function automatic logic [2:0] coin_units(input logic [1:0] code);
        logic [2:0] units;
        case (code)
            COIN_5:  units = 3'd1;
            COIN_10: units = 3'd2;
            COIN_20: units = 3'd4;
            default: units = 3'd0;
        endcase
        return units;
    endfunction

    function automatic logic [1:0] greedy_coin(input logic [GREEDY_W-1:0] remaining);
        logic [1:0] code;
        if (remaining >= GREEDY_W'(4))
            code = COIN_20;
        else if (remaining >= GREEDY_W'(2))
            code = COIN_10;
        else if (remaining != '0)
            code = COIN_5;
        else
            code = COIN_NONE;
        return code;
    endfunction

endpackage

// File: rtl/iiitb_vm_change_gen.sv
// Change dispenser: loads an amount and emits one greedy coin per cycle.
// done is high whenever nothing is left to pay out.
module iiitb_vm_change_gen
    import iiitb_vm_pkg::*;
#(
    parameter int CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                load,
    input  logic [CREDIT_W-1:0] load_val,
    output logic [1:0]          change,
    output logic                change_valid,
    output logic                done
);

    logic [CREDIT_W-1:0] remaining_reg;
    logic [CREDIT_W-1:0] source;
    logic [1:0]          coin;
    logic [CREDIT_W-1:0] coin_val;

    // The first coin is paid in the same edge as the load so the refund
    // appears on the cycle right after the request.
    assign source   = load ? load_val : remaining_reg;
    assign coin     = greedy_coin(GREEDY_W'(source));
    assign coin_val = CREDIT_W'(coin_units(coin));
    assign done     = (remaining_reg == '0);

    always_ff @(posedge clk) begin
        if (srst) begin
            remaining_reg <= '0;
            change        <= COIN_NONE;
            change_valid  <= 1'b0;
        end else if (source != '0) begin
            remaining_reg <= source - coin_val;
            change        <= coin;
            change_valid  <= 1'b1;
        end else begin
            remaining_reg <= '0;
            change        <= COIN_NONE;
            change_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/iiitb_vm_multi.sv
// Multi-product vending controller: collects credit, vends a selected item,
// then hands any balance to the change generator.
module iiitb_vm_multi
    import iiitb_vm_pkg::*;
#(
    parameter int                          NUM_ITEMS = 4,
    parameter int                          CREDIT_W  = 6,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES  = {6'd6, 6'd5, 6'd4, 6'd3},
    parameter int                          ITEM_W    = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          in,
    input  logic                sel_valid,
    input  logic [ITEM_W-1:0]   sel,
    input  logic                cancel,
    output logic                out,
    output logic [ITEM_W-1:0]   out_item,
    output logic [1:0]          change,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject,
    output logic                sel_err
);

    localparam int TAB_N = 2 ** ITEM_W;
    localparam logic [CREDIT_W:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

    state_t              state_reg;
    logic [CREDIT_W-1:0] credit_reg;
    logic [CREDIT_W-1:0] remaining_reg;
    logic                out_reg;
    logic [ITEM_W-1:0]   out_item_reg;
    logic                busy_reg;
    logic                coin_reject_reg;
    logic                sel_err_reg;

    logic [CREDIT_W-1:0] price_tab [TAB_N];
    logic [TAB_N-1:0]    item_ok;

    // Indices past NUM_ITEMS decode as invalid so a stray select is flagged.
    generate
        for (genvar gi = 0; gi < TAB_N; gi++) begin : g_price
            if (gi < NUM_ITEMS) begin : g_item
                assign price_tab[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
                assign item_ok[gi]   = 1'b1;
            end else begin : g_none
                assign price_tab[gi] = '0;
                assign item_ok[gi]   = 1'b0;
            end
        end
    endgenerate

    logic [CREDIT_W-1:0] sel_price;
    logic                sel_fund_ok;
    logic                coin_in;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;

    assign sel_price   = price_tab[sel];
    assign sel_fund_ok = item_ok[sel] && (credit_reg >= sel_price);
    assign coin_in     = (in != COIN_NONE);
    assign coin_sum    = {1'b0, credit_reg} + (CREDIT_W+1)'(coin_units(in));
    assign coin_fits   = (coin_sum <= CREDIT_MAX);

    logic                gen_load;
    logic [CREDIT_W-1:0] gen_load_val;
    logic                gen_done;

    always_comb begin
        gen_load     = 1'b0;
        gen_load_val = '0;
        if (state_reg == COLLECT && cancel && credit_reg != '0) begin
            gen_load     = 1'b1;
            gen_load_val = credit_reg;
        end else if (state_reg == VEND && remaining_reg != '0) begin
            gen_load     = 1'b1;
            gen_load_val = remaining_reg;
        end
    end

    iiitb_vm_change_gen #(
        .CREDIT_W (CREDIT_W)
    ) u_change_gen (
        .clk          (clk),
        .srst         (rst),
        .load         (gen_load),
        .load_val     (gen_load_val),
        .change       (change),
        .change_valid (change_valid),
        .done         (gen_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= COLLECT;
            credit_reg      <= '0;
            remaining_reg   <= '0;
            out_reg         <= 1'b0;
            out_item_reg    <= '0;
            busy_reg        <= 1'b0;
            coin_reject_reg <= 1'b0;
            sel_err_reg     <= 1'b0;
        end else begin
            out_reg         <= 1'b0;
            coin_reject_reg <= 1'b0;
            sel_err_reg     <= 1'b0;
            case (state_reg)
                COLLECT: begin
                    if (cancel) begin
                        coin_reject_reg <= coin_in;
                        credit_reg      <= '0;
                        if (credit_reg != '0) begin
                            state_reg <= CHANGE;
                            busy_reg  <= 1'b1;
                        end
                    end else if (sel_valid && sel_fund_ok) begin
                        coin_reject_reg <= coin_in;
                        remaining_reg   <= credit_reg - sel_price;
                        credit_reg      <= '0;
                        out_reg         <= 1'b1;
                        out_item_reg    <= sel;
                        state_reg       <= VEND;
                        busy_reg        <= 1'b1;
                    end else begin
                        sel_err_reg <= sel_valid;
                        if (coin_in) begin
                            if (coin_fits)
                                credit_reg <= coin_sum[CREDIT_W-1:0];
                            else
                                coin_reject_reg <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    coin_reject_reg <= coin_in;
                    remaining_reg   <= '0;
                    if (remaining_reg != '0) begin
                        state_reg <= CHANGE;
                        busy_reg  <= 1'b1;
                    end else begin
                        state_reg <= COLLECT;
                        busy_reg  <= 1'b0;
                    end
                end
                CHANGE: begin
                    coin_reject_reg <= coin_in;
                    if (gen_done) begin
                        state_reg <= COLLECT;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= COLLECT;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign out         = out_reg;
    assign out_item    = out_item_reg;
    assign credit      = credit_reg;
    assign busy        = busy_reg;
    assign coin_reject = coin_reject_reg;
    assign sel_err     = sel_err_reg;

endmodule

// File: tb/tb_iiitb_vm_multi.sv
// Directed bench for iiitb_vm_multi: hand-computed expectations checked
// with immediate assertions one cycle after each stimulus.
module tb_iiitb_vm_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic       out;
    logic [1:0] out_item;
    logic [1:0] change;
    logic       change_valid;
    logic [5:0] credit;
    logic       busy;
    logic       coin_reject;
    logic       sel_err;

    int vectors = 0;
    int miscompares = 0;

    iiitb_vm_multi dut (
        .clk          (clk),
        .rst          (rst),
        .in           (in),
        .sel_valid    (sel_valid),
        .sel          (sel),
        .cancel       (cancel),
        .out          (out),
        .out_item     (out_item),
        .change       (change),
        .change_valid (change_valid),
        .credit       (credit),
        .busy         (busy),
        .coin_reject  (coin_reject),
        .sel_err      (sel_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
        $display("chk %-24s observed %0d expected %0d", tag, observed, expected);
    endtask

    initial begin
        int n;
        rst = 1'b1; in = 2'd0; sel_valid = 1'b0; sel = 2'd0; cancel = 1'b0;
        step(); step();
        chk("rst_credit", credit, 0);
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cv", change_valid, 0);
        chk("rst_change", change, 0);
        chk("rst_reject", coin_reject, 0);
        chk("rst_selerr", sel_err, 0);
        rst = 1'b0;

        // 10+10 Rs, buy item0 (3 units), one 5 Rs coin back
        in = 2'd2; step(); chk("t1_credit2", credit, 2);
        in = 2'd2; step(); chk("t1_credit4", credit, 4);
        in = 2'd0; sel_valid = 1'b1; sel = 2'd0; step();
        chk("t1_out", out, 1);
        chk("t1_item", out_item, 0);
        chk("t1_busy", busy, 1);
        chk("t1_credit0", credit, 0);
        sel_valid = 1'b0; step();
        chk("t1_out_drop", out, 0);
        chk("t1_change", change, 1);
        chk("t1_cv", change_valid, 1);
        step();
        chk("t1_cv_end", change_valid, 0);
        chk("t1_busy_end", busy, 0);

        // underfunded item3, then top up and buy with exact money
        in = 2'd3; step(); chk("t2_credit4", credit, 4);
        in = 2'd0; sel_valid = 1'b1; sel = 2'd3; step();
        chk("t2_selerr", sel_err, 1);
        chk("t2_credit_kept", credit, 4);
        chk("t2_no_out", out, 0);
        sel_valid = 1'b0; in = 2'd2; step();
        chk("t2_selerr_drop", sel_err, 0);
        chk("t2_credit6", credit, 6);
        in = 2'd0; sel_valid = 1'b1; sel = 2'd3; step();
        chk("t2_out", out, 1);
        chk("t2_item", out_item, 3);
        sel_valid = 1'b0; step();
        chk("t2_no_change", change_valid, 0);
        chk("t2_busy_end", busy, 0);

        // 9 units then cancel: refund 20,20,5
        in = 2'd3; step(); in = 2'd3; step(); in = 2'd1; step();
        chk("t3_credit9", credit, 9);
        in = 2'd0; cancel = 1'b1; step();
        chk("t3_c1", change, 3);
        chk("t3_cv1", change_valid, 1);
        chk("t3_credit0", credit, 0);
        cancel = 1'b0; step();
        chk("t3_c2", change, 3);
        step();
        chk("t3_c3", change, 1);
        chk("t3_busy3", busy, 1);
        step();
        chk("t3_cv_end", change_valid, 0);
        chk("t3_busy_end", busy, 0);

        // overflow boundary at 63 units
        for (int i = 0; i < 15; i++) begin
            in = 2'd3; step();
        end
        chk("t4_credit60", credit, 60);
        in = 2'd3; step();
        chk("t4_reject20", coin_reject, 1);
        chk("t4_credit60b", credit, 60);
        in = 2'd1; step(); chk("t4_credit61", credit, 61);
        chk("t4_accept", coin_reject, 0);
        in = 2'd1; step(); chk("t4_credit62", credit, 62);
        in = 2'd1; step(); chk("t4_credit63", credit, 63);
        in = 2'd1; step();
        chk("t4_reject5", coin_reject, 1);
        chk("t4_credit63b", credit, 63);
        in = 2'd0; cancel = 1'b1; step();
        cancel = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && change_valid; i++) begin
            n++;
            step();
        end
        chk("t4_refund_coins", n, 17);
        chk("t4_busy_end", busy, 0);

        // select and coin in the same cycle: vend wins, coin returned
        in = 2'd3; step(); chk("t5_credit4", credit, 4);
        in = 2'd1; sel_valid = 1'b1; sel = 2'd1; step();
        chk("t5_out", out, 1);
        chk("t5_item", out_item, 1);
        chk("t5_reject", coin_reject, 1);
        chk("t5_credit0", credit, 0);
        in = 2'd0; sel_valid = 1'b0; step();
        chk("t5_no_change", change_valid, 0);
        chk("t5_busy_end", busy, 0);

        // coins offered while vending and paying change are rejected
        in = 2'd2; step(); in = 2'd2; step();
        in = 2'd0; sel_valid = 1'b1; sel = 2'd0; step();
        chk("t5b_out", out, 1);
        sel_valid = 1'b0; in = 2'd2; step();
        chk("t5b_vend_reject", coin_reject, 1);
        chk("t5b_cv", change_valid, 1);
        in = 2'd2; step();
        chk("t5b_change_reject", coin_reject, 1);
        chk("t5b_credit0", credit, 0);
        in = 2'd0; step();
        chk("t5b_credit_still0", credit, 0);
        chk("t5b_reject_drop", coin_reject, 0);

        // reset during the second coin of a 3-coin refund
        in = 2'd3; step(); in = 2'd3; step(); in = 2'd1; step();
        in = 2'd0; cancel = 1'b1; step();
        cancel = 1'b0; step();
        chk("t6_c2", change, 3);
        rst = 1'b1; step();
        chk("t6_cv", change_valid, 0);
        chk("t6_change", change, 0);
        chk("t6_credit", credit, 0);
        chk("t6_busy", busy, 0);
        rst = 1'b0; in = 2'd1; step();
        chk("t6_credit1", credit, 1);
        chk("t6_accept", coin_reject, 0);
        in = 2'd0; step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iiitb_vm_multi.md
Name: iiitb_vm_multi

Overview:
Parametrised multi-product vending controller, successor to the single-product coin vending FSM. Accepts 5/10/20-rupee coins and accumulates credit. Vends one of NUM_ITEMS products at per-item prices, then returns change one coin per cycle using the fewest coins. Supports cancel/refund and rejects coins it cannot hold. Sits between the coin-acceptor front end and the dispenser/coin-hopper drivers.

Parameters:
NUM_ITEMS, 4, number of selectable products (1..16).
CREDIT_W, 6, credit register width, in 5-rupee units; max credit 2**CREDIT_W-1.
PRICES, {6'd6,6'd5,6'd4,6'd3}, packed NUM_ITEMS*CREDIT_W prices in 5-rupee units; item i occupies bits [i*CREDIT_W +: CREDIT_W]; default item0=15, item1=20, item2=25, item3=30 rupees.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in  in  2  coin code, sampled every cycle: 0 none, 1 = 5 Rs (1 unit), 2 = 10 Rs (2 units), 3 = 20 Rs (4 units)
sel_valid  in  1  product selection strobe
sel  in  ITEM_W  product index; ITEM_W = max(1,$clog2(NUM_ITEMS))
cancel  in  1  refund request
out  out  1  vend pulse, 1 cycle
out_item  out  ITEM_W  index of vended item; valid while out=1
change  out  2  change coin code, same encoding as in; 0 when idle
change_valid  out  1  one change coin is dispensed this cycle
credit  out  CREDIT_W  current credit in units
busy  out  1  high in VEND and CHANGE states
coin_reject  out  1  1-cycle pulse: previous cycle's coin was not accepted and is returned
sel_err  out  1  1-cycle pulse: previous selection was invalid or underfunded

Behaviour:
- Reset: state=COLLECT, credit=0, remaining=0. Outputs out, out_item, change, change_valid, busy, coin_reject and sel_err are all 0.
- All outputs are registered. Every response appears the cycle after the input that caused it.
- States: COLLECT, VEND, CHANGE.
- COLLECT, priority per cycle is cancel > sel_valid > coin:
  - cancel: remaining<=credit, credit<=0. Go to CHANGE if credit>0, else stay. Any coin in the same cycle is rejected.
  - sel_valid with sel<NUM_ITEMS and credit>=PRICES[sel]: remaining<=credit-price, credit<=0, out_item<=sel, go to VEND. A same-cycle coin is rejected.
  - sel_valid that is out of range or underfunded: sel_err pulse, no state change. A coin in the same cycle is still evaluated normally.
  - coin (in!=0): if credit+value <= 2**CREDIT_W-1, then credit<=credit+value. Otherwise coin_reject pulses and credit is unchanged.
- VEND, exactly one cycle: out=1, busy=1. Next state is CHANGE if remaining>0, else COLLECT.
- CHANGE: each cycle, emit the largest coin not exceeding remaining (4, then 2, then 1 unit), set change_valid=1, and subtract its value. Return to COLLECT on the cycle remaining reaches 0. Number of cycles = greedy coin count.
- VEND/CHANGE: all coins are rejected via coin_reject. sel_valid and cancel are ignored and raise no sel_err.
- Arithmetic: the sum is computed at CREDIT_W+1 bits for the overflow check. Credit never wraps.
- rst mid-VEND/CHANGE: abort immediately, drop the remaining change, and clear credit. Rst has priority over all inputs.

Decomposition:
- Package iiitb_vm_pkg holds:
  - state enum {COLLECT, VEND, CHANGE};
  - coin code constants COIN_NONE/5/10/20;
  - function coin_units(code) returning unit value;
  - function greedy_coin(remaining) returning code.
- One sub-module, iiitb_vm_change_gen: loads remaining, emits one coin per cycle, and raises done. The top FSM owns credit and selection.

Test Plan:
- Reset, then coins 2,2 on consecutive cycles, then sel=0 → credit reaches 4. out=1 with out_item=0 one cycle after sel. Then change=1 (5 Rs) for one cycle, and credit=0.
- Coin 3 (20 Rs), then sel=3 (price 6) → sel_err pulse, credit stays 4. Coins 2, then sel=3 → out=1 and no change cycles.
- Coins 3,3,1 (9 units), then cancel → change sequence 3,3,1 over 3 cycles, change_valid high for 3 cycles, then busy=0.
- Fill credit to 60 with coin 3 ×15, then coin 3 → coin_reject, credit stays 60. Coin 1 three times → credit 63. Coin 1 again → coin_reject.
- Same-cycle sel_valid=1 (sel=1, credit 4) and in=1 → vend item1, coin_reject pulse, zero change. Coin inserted during CHANGE → coin_reject and no credit change.
- rst asserted during the second change cycle of a 3-coin refund → next cycle change_valid=0, credit=0, state COLLECT. A subsequent coin 1 is credited normally.
